// File: rtl/rf_restore_pkg.sv
// Shared types for the lockstep register-file restore sequencer.
package rf_restore_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        COPY,
        DRAIN,
        DONE
    } state_e;

    // Register 0 is hardwired to zero on cores that skip it, so the copy starts at 1.
    function automatic int unsigned first_addr(input int unsigned skip_zero);
        return (skip_zero != 0) ? 1 : 0;
    endfunction

endpackage

// File: rtl/rf_restore_seq.sv
// Restore sequencer: on a lockstep mismatch, halts both cores and replays the
// golden register file into both cores' register-file write ports.
module rf_restore_seq
    import rf_restore_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SKIP_ZERO  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  error_i,
    output logic                  cmp_enable_o,
    output logic                  halt_o,
    input  logic                  halt_ack_i,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  we_a_o,
    output logic                  we_b_o,
    output logic [ADDR_WIDTH-1:0] addr_a_o,
    output logic [ADDR_WIDTH-1:0] addr_b_o,
    output logic [DATA_WIDTH-1:0] data_a_o,
    output logic [DATA_WIDTH-1:0] data_b_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [ADDR_WIDTH-1:0] FIRST = ADDR_WIDTH'(first_addr(SKIP_ZERO));
    localparam logic [ADDR_WIDTH-1:0] LAST  = '1;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic                    pipe_vld_q, pipe_vld_d;
    logic [ADDR_WIDTH-1:0]   pipe_addr_q, pipe_addr_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    cmp_en_q, cmp_en_d;
    logic                    halt_q, halt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        pipe_vld_d  = 1'b0;
        pipe_addr_d = pipe_addr_q;
        // Write stage: data arrives one cycle after the address was issued.
        we_d        = pipe_vld_q;
        waddr_d     = pipe_vld_q ? pipe_addr_q : waddr_q;
        wdata_d     = pipe_vld_q ? rd_data_i : wdata_q;

        unique case (state_q)
            IDLE: begin
                if (error_i) state_d = HALT;
            end
            HALT: begin
                ptr_d = FIRST;
                if (halt_ack_i) state_d = COPY;
            end
            COPY: begin
                pipe_vld_d  = 1'b1;
                pipe_addr_d = ptr_q;
                // Stop on the all-ones address so the pointer never wraps to 0.
                if (ptr_q == LAST) state_d = DRAIN;
                else               ptr_d   = ptr_q + ADDR_WIDTH'(1);
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cmp_en_d = (state_d == IDLE);
        halt_d   = (state_d != IDLE);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            pipe_vld_q  <= 1'b0;
            pipe_addr_q <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            cmp_en_q    <= 1'b1;
            halt_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_addr_q <= pipe_addr_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            cmp_en_q    <= cmp_en_d;
            halt_q      <= halt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cmp_enable_o = cmp_en_q;
    assign halt_o       = halt_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign rd_addr_o    = ptr_q;
    assign we_a_o       = we_q;
    assign we_b_o       = we_q;
    assign addr_a_o     = waddr_q;
    assign addr_b_o     = waddr_q;
    assign data_a_o     = wdata_q;
    assign data_b_o     = wdata_q;

endmodule

// File: tb/tb_rf_restore_seq.sv
// Bench for rf_restore_seq: two instances (SKIP_ZERO=1 and 0) share stimulus;
// a golden-RF array and an expected-write list built from it judge every restore.
module tb_rf_restore_seq;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        bit            err, ack;
        bit            cmp, halt, busy, done, we;
        logic [AW-1:0] rd, wa;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          err = 1'b0;
    logic          ack = 1'b0;
    logic          cmp [2], halt [2], busy [2], done [2], we_a [2], we_b [2];
    logic [AW-1:0] rd_addr [2], addr_a [2], addr_b [2];
    logic [DW-1:0] rd_data [2], data_a [2], data_b [2];
    logic [DW-1:0] gmem [NREG];

    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;
    int  ndone [2], done_edge [2], fall_edge [2];
    bit  halt_prev [2];
    wr_t wq0[$], wq1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    rf_restore_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SKIP_ZERO(1)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .error_i(err), .cmp_enable_o(cmp[0]),
        .halt_o(halt[0]), .halt_ack_i(ack), .rd_addr_o(rd_addr[0]), .rd_data_i(rd_data[0]),
        .we_a_o(we_a[0]), .we_b_o(we_b[0]), .addr_a_o(addr_a[0]), .addr_b_o(addr_b[0]),
        .data_a_o(data_a[0]), .data_b_o(data_b[0]), .busy_o(busy[0]), .done_o(done[0]));

    rf_restore_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SKIP_ZERO(0)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .error_i(err), .cmp_enable_o(cmp[1]),
        .halt_o(halt[1]), .halt_ack_i(ack), .rd_addr_o(rd_addr[1]), .rd_data_i(rd_data[1]),
        .we_a_o(we_a[1]), .we_b_o(we_b[1]), .addr_a_o(addr_a[1]), .addr_b_o(addr_b[1]),
        .data_a_o(data_a[1]), .data_b_o(data_b[1]), .busy_o(busy[1]), .done_o(done[1]));

    // Golden register file with a synchronous read.
    always @(posedge clk) begin
        rd_data[0] <= gmem[rd_addr[0]];
        rd_data[1] <= gmem[rd_addr[1]];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle invariants and event capture; cyc is the edge that produced the values.
    task automatic mon(input int u);
        chk($sformatf("u%0d_we_ab", u), we_a[u], we_b[u]);
        chk($sformatf("u%0d_cmp_vs_busy", u), cmp[u], !busy[u]);
        chk($sformatf("u%0d_halt_vs_busy", u), halt[u], busy[u]);
        if (we_a[u]) begin
            chk($sformatf("u%0d_addr_ab", u), addr_a[u], addr_b[u]);
            chk($sformatf("u%0d_data_ab", u), data_a[u], data_b[u]);
        end
        if (done[u]) begin
            ndone[u]++;
            done_edge[u] = cyc;
        end
        if (halt_prev[u] && !halt[u]) fall_edge[u] = cyc;
        halt_prev[u] = halt[u];
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (we_a[0]) wq0.push_back('{addr_a[0], data_a[0]});
            if (we_a[1]) wq1.push_back('{addr_a[1], data_a[1]});
            mon(0);
            mon(1);
        end
    end

    task automatic clear_run();
        wq0.delete();
        wq1.delete();
        for (int u = 0; u < 2; u++) begin
            ndone[u] = 0;
            done_edge[u] = -1;
            fall_edge[u] = -1;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("%s_u%0d_cmp", tag, u), cmp[u], 1);
            chk($sformatf("%s_u%0d_halt", tag, u), halt[u], 0);
            chk($sformatf("%s_u%0d_busy", tag, u), busy[u], 0);
            chk($sformatf("%s_u%0d_done", tag, u), done[u], 0);
            chk($sformatf("%s_u%0d_we", tag, u), {we_a[u], we_b[u]}, 0);
            chk($sformatf("%s_u%0d_rd", tag, u), rd_addr[u], 0);
            chk($sformatf("%s_u%0d_addr", tag, u), {addr_a[u], addr_b[u]}, 0);
            chk($sformatf("%s_u%0d_data", tag, u), {data_a[u], data_b[u]}, 0);
        end
    endtask

    // Reference: every address from the first restored one up to the top, in order,
    // carrying the golden contents; done seen by edge h+N+2, halt gone by h+N+3.
    task automatic check_run(input int u, input int h);
        wr_t exp_q[$];
        wr_t got[$];
        int  first = (u == 0) ? 1 : 0;
        int  n;
        if (u == 0) got = wq0; else got = wq1;
        for (int k = first; k < NREG; k++) exp_q.push_back('{AW'(k), gmem[k]});
        n = exp_q.size();
        chk($sformatf("u%0d_nwrites", u), got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) begin
            chk($sformatf("u%0d_waddr[%0d]", u, i), got[i].a, exp_q[i].a);
            chk($sformatf("u%0d_wdata[%0d]", u, i), got[i].d, exp_q[i].d);
        end
        chk($sformatf("u%0d_done_pulses", u), ndone[u], 1);
        chk($sformatf("u%0d_done_edge", u), done_edge[u] + 1, h + n + 2);
        chk($sformatf("u%0d_halt_fall_edge", u), fall_edge[u] + 1, h + n + 3);
    endtask

    task automatic finish_restore(input int h, input bit reassert, input bit drop);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            err = reassert && (cyc == h + 5);
            if (drop && cyc == h + 3) ack = 1'b0;
            if (fall_edge[0] >= 0 && fall_edge[1] >= 0) begin
                ok = 1'b1;
                break;
            end
        end
        err = 1'b0;
        ack = 1'b0;
        chk("restore_completes", ok, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_restore(input int ack_dly, input bit early, input bit reassert,
                              input bit drop, output int h);
        int t;
        clear_run();
        err = 1'b1;
        ack = early;
        @(posedge clk); #1;
        t   = cyc;
        err = 1'b0;
        chk("halt_after_error", {halt[0], halt[1], cmp[0], cmp[1]}, 4'b1100);
        if (early) begin
            h = t + 1;
        end else begin
            for (int i = 0; i < ack_dly; i++) begin
                @(posedge clk); #1;
                chk("wait_ack_halt", {halt[0], halt[1], cmp[0], cmp[1]}, 4'b1100);
                chk("wait_ack_no_write", {we_a[0], we_a[1]}, 0);
            end
            if (ack_dly > 1) chk("wait_ack_rd_hold", {rd_addr[0], rd_addr[1]}, {5'd1, 5'd0});
            chk("wait_ack_queue_empty", wq0.size() + wq1.size(), 0);
            ack = 1'b1;
            h   = cyc + 1;
        end
        finish_restore(h, reassert, drop);
    endtask

    initial begin
        vec_t tbl[7];
        int   h;

        tbl[0] = '{0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0};
        tbl[1] = '{1, 1, 0, 1, 1, 0, 0, 5'd0, 5'd0};
        tbl[2] = '{0, 1, 0, 1, 1, 0, 0, 5'd1, 5'd0};
        tbl[3] = '{0, 0, 0, 1, 1, 0, 0, 5'd2, 5'd0};
        tbl[4] = '{0, 0, 0, 1, 1, 0, 1, 5'd3, 5'd1};
        tbl[5] = '{1, 0, 0, 1, 1, 0, 1, 5'd4, 5'd2};
        tbl[6] = '{0, 0, 0, 1, 1, 0, 1, 5'd5, 5'd3};

        for (int k = 0; k < NREG; k++) gmem[k] = 32'hA5A5_0000 + k;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        clear_run();
        mon_en = 1'b1;

        // Idle for 100 cycles: comparator enabled, nothing written.
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (i % 25 == 0 || i == 99) chk_reset_outputs("idle");
        end
        chk("idle_no_writes", wq0.size() + wq1.size(), 0);

        // Cycle-exact start: error+ack on one edge, ack held, ack drop, error during COPY.
        clear_run();
        h = 0;
        for (int i = 0; i < 7; i++) begin
            err = tbl[i].err;
            ack = tbl[i].ack;
            @(posedge clk); #1;
            if (i == 2) h = cyc;
            chk($sformatf("vec%0d_flags", i), {cmp[0], halt[0], busy[0], done[0], we_a[0]},
                {tbl[i].cmp, tbl[i].halt, tbl[i].busy, tbl[i].done, tbl[i].we});
            chk($sformatf("vec%0d_rd_addr", i), rd_addr[0], tbl[i].rd);
            if (tbl[i].we) chk($sformatf("vec%0d_waddr", i), addr_a[0], tbl[i].wa);
        end
        err = 1'b0;
        finish_restore(h, 1'b0, 1'b0);
        check_run(0, h);
        check_run(1, h);

        // Plain restore, ack three cycles after HALT, then the same with error during COPY.
        do_restore(3, 1'b0, 1'b0, 1'b0, h);
        check_run(0, h);
        check_run(1, h);
        do_restore(3, 1'b0, 1'b1, 1'b0, h);
        check_run(0, h);
        check_run(1, h);

        // Reset during the 10th write, then a complete fresh restore.
        clear_run();
        err = 1'b1;
        @(posedge clk); #1;
        err = 1'b0;
        ack = 1'b1;
        for (int i = 0; i < 200 && wq0.size() < 10; i++) begin
            @(negedge clk); #1;
        end
        chk("mid_reset_reached_10", wq0.size(), 10);
        rst_n = 1'b0;
        ack   = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs("mid_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_restore(2, 1'b0, 1'b0, 1'b0, h);
        check_run(0, h);
        check_run(1, h);

        // Cores slow to acknowledge.
        do_restore(50, 1'b0, 1'b0, 1'b0, h);
        check_run(0, h);
        check_run(1, h);

        // Randomized golden contents and handshake shapes.
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < NREG; k++) gmem[k] = $urandom;
            do_restore(int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), h);
            check_run(0, h);
            check_run(1, h);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
